// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 sequential multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Round-robin successor of a channel index, wrapping from n-1 to 0.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_comb.sv
// Purely combinational N-way, W-bit channel select.
// Channel k occupies din_i[k*W +: W]; out-of-range selects yield zero.
module mux_nx1_comb #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic [$clog2(N)-1:0] sel_i,
  input  logic [N*W-1:0]       din_i,
  output logic [W-1:0]         y_o
);

  localparam int SEL_W = $clog2(N);

  // Compare-and-pick over every channel so non-power-of-2 N never indexes past din_i.
  always_comb begin
    y_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) y_o = din_i[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_nx1_seq.sv
// N-to-1, W-bit multiplexer with a registered output stage and valid/ready
// output handshake. Manual mode loads the channel from sel; scan mode steps
// round-robin one channel per accepted sample.
// Optional: define MUX_CH_MASK_EN to add the ch_mask port (scan-mode channel skip).
module mux_nx1_seq
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  input  logic                 sel_load,
  input  logic [N*W-1:0]       din,
`ifdef MUX_CH_MASK_EN
  input  logic [N-1:0]         ch_mask,
`endif
  input  logic                 en,
  input  logic                 out_ready,
  output logic [W-1:0]         y,
  output logic                 y_valid,
  output logic [$clog2(N)-1:0] cur_sel,
  output logic [$clog2(N)-1:0] y_ch
);

  localparam int SEL_W = $clog2(N);

  logic [W-1:0]     y_q, y_d, mux_y;
  logic             y_valid_q, y_valid_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] y_ch_q, y_ch_d;
  logic [SEL_W-1:0] scan_next;
  logic             blocked;
  logic             capture, transfer, load_ok;

  mux_nx1_comb #(.N(N), .W(W)) u_mux (
    .sel_i (cur_sel_q),
    .din_i (din),
    .y_o   (mux_y)
  );

`ifdef MUX_CH_MASK_EN
  // Next unmasked channel after cur_sel (circular; falls back to cur_sel itself),
  // and suppression of scan captures on a masked channel.
  always_comb begin
    int unsigned cand;
    logic        found;
    cand      = 32'(cur_sel_q);
    found     = 1'b0;
    scan_next = cur_sel_q;
    for (int unsigned i = 0; i < N; i++) begin
      cand = next_idx(cand, N);
      if (!found && !ch_mask[cand]) begin
        scan_next = SEL_W'(cand);
        found     = 1'b1;
      end
    end
    blocked = (mode == MODE_SCAN) && ch_mask[cur_sel_q];
  end
`else
  // Plain round-robin successor; nothing is ever masked.
  always_comb begin
    scan_next = SEL_W'(next_idx(32'(cur_sel_q), N));
    blocked   = 1'b0;
  end
`endif

  // Handshake decode and next-state for output stage and select register.
  always_comb begin
    capture   = en && (!y_valid_q || out_ready) && !blocked;
    transfer  = y_valid_q && out_ready;
    load_ok   = sel_load && (32'(sel) < N);

    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q;
    if (capture) begin
      y_d       = mux_y;
      y_ch_d    = cur_sel_q;
      y_valid_d = 1'b1;
    end else if (transfer) begin
      y_valid_d = 1'b0;
    end

    // Capture samples the old cur_sel; a valid load overrides the scan advance.
    cur_sel_d = cur_sel_q;
    if (load_ok) begin
      cur_sel_d = sel;
    end else if ((mode == MODE_SCAN) && capture) begin
      cur_sel_d = scan_next;
    end
  end

  // State registers with synchronous reset dropping any pending sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      cur_sel_q <= '0;
      y_ch_q    <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      cur_sel_q <= cur_sel_d;
      y_ch_q    <= y_ch_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign cur_sel = cur_sel_q;
  assign y_ch    = y_ch_q;

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Self-checking bench for mux_nx1_seq with N=4, W=8.
// Define MUX_CH_MASK_EN to also exercise the channel mask.
module tb_mux_nx1_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic        sel_load;
  logic [31:0] din;
  logic        en;
  logic        out_ready;
  logic [7:0]  y;
  logic        y_valid;
  logic [1:0]  cur_sel;
  logic [1:0]  y_ch;
`ifdef MUX_CH_MASK_EN
  logic [3:0]  ch_mask;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
  } exp_t;

  exp_t sb[$];
  int   m_sel;
  logic m_valid;
  logic m_xfer, m_cap, m_block;
  exp_t e;

  mux_nx1_seq #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .sel_load  (sel_load),
    .din       (din),
`ifdef MUX_CH_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .en        (en),
    .out_ready (out_ready),
    .y         (y),
    .y_valid   (y_valid),
    .cur_sel   (cur_sel),
    .y_ch      (y_ch)
  );

  always #5 clk = ~clk;

  // Scoreboard model: predicts captures/transfers at the negedge preceding each
  // active edge, pushes expected samples and pops them when the DUT hands them off.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_sel   = 0;
      m_valid = 1'b0;
    end else begin
      n_checks++;
      if (y_valid !== m_valid)
        $display("FAIL sb_valid: y_valid=%b required %b at %0t", y_valid, m_valid, $time);
      else n_pass++;

      m_block = 1'b0;
`ifdef MUX_CH_MASK_EN
      m_block = mode && ch_mask[m_sel];
`endif
      m_xfer = m_valid && out_ready;
      m_cap  = en && (!m_valid || out_ready) && !m_block;

      if (m_xfer) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_empty: transfer with no expected sample at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (y !== e.d || y_ch !== e.ch)
            $display("FAIL sb_data: y=%h y_ch=%0d required y=%h y_ch=%0d at %0t",
                     y, y_ch, e.d, e.ch, $time);
          else n_pass++;
        end
      end

      if (m_cap) sb.push_back({din[m_sel*8 +: 8], 2'(m_sel)});

      if (sel_load) begin
        m_sel = int'(sel);
      end else if (mode && m_cap) begin
`ifdef MUX_CH_MASK_EN
        begin
          int nxt;
          nxt = m_sel;
          for (int off = 4; off >= 1; off--)
            if (!ch_mask[(m_sel + off) % 4]) nxt = (m_sel + off) % 4;
          m_sel = nxt;
        end
`else
        m_sel = (m_sel + 1) % 4;
`endif
      end
      m_valid = m_cap || (m_valid && !m_xfer);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; out_ready = 1'b1; sel_load = 1'b0; sel = 2'd0;
    step();
    step();
    n_checks++; if (y !== 8'h00) $display("FAIL reset_y: got %h required 00", y); else n_pass++;
    n_checks++; if (y_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", y_valid); else n_pass++;
    n_checks++; if (cur_sel !== 2'd0) $display("FAIL reset_sel: got %0d required 0", cur_sel); else n_pass++;
    rst = 1'b0;
    step();
    n_checks++; if (y !== 8'h11) $display("FAIL reset_first_y: got %h required 11", y); else n_pass++;
    n_checks++; if (y_ch !== 2'd0) $display("FAIL reset_first_ch: got %0d required 0", y_ch); else n_pass++;
    en = 1'b0;
    step();
  endtask

  task automatic test_manual();
    mode = 1'b0; sel = 2'd2; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    n_checks++; if (cur_sel !== 2'd2) $display("FAIL manual_load: got %0d required 2", cur_sel); else n_pass++;
    en = 1'b1;
    step();
    n_checks++; if (y !== 8'h33) $display("FAIL manual_y: got %h required 33", y); else n_pass++;
    n_checks++; if (y_ch !== 2'd2) $display("FAIL manual_ch: got %0d required 2", y_ch); else n_pass++;
    step();
    step();
    n_checks++; if (y !== 8'h33) $display("FAIL manual_hold_y: got %h required 33", y); else n_pass++;
    n_checks++; if (cur_sel !== 2'd2) $display("FAIL manual_hold_sel: got %0d required 2", cur_sel); else n_pass++;
    en = 1'b0;
    step();
  endtask

  task automatic test_scan_wrap();
    logic [7:0] exp_y  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sel = 2'd0; sel_load = 1'b1;
    step();
    sel_load = 1'b0; mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (y !== exp_y[i] || y_ch !== exp_ch[i])
        $display("FAIL scan_wrap[%0d]: got y=%h ch=%0d required y=%h ch=%0d", i, y, y_ch, exp_y[i], exp_ch[i]);
      else n_pass++;
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    sel = 2'd0; sel_load = 1'b1;
    step();
    sel_load = 1'b0; en = 1'b1; out_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (y !== 8'h11 || y_valid !== 1'b1 || cur_sel !== 2'd1)
        $display("FAIL bp_hold[%0d]: got y=%h v=%b sel=%0d required y=11 v=1 sel=1", i, y, y_valid, cur_sel);
      else n_pass++;
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (y !== 8'h22 || y_ch !== 2'd1)
      $display("FAIL bp_resume: got y=%h ch=%0d required y=22 ch=1", y, y_ch);
    else n_pass++;
    en = 1'b0;
    step();
  endtask

  task automatic test_collision();
    sel = 2'd1; sel_load = 1'b1;
    step();
    mode = 1'b1; en = 1'b1; out_ready = 1'b1; sel = 2'd3; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    n_checks++; if (y !== 8'h22) $display("FAIL coll_y: got %h required 22", y); else n_pass++;
    n_checks++; if (cur_sel !== 2'd3) $display("FAIL coll_sel: got %0d required 3", cur_sel); else n_pass++;
    step();
    n_checks++;
    if (y !== 8'h44 || y_ch !== 2'd3) $display("FAIL coll_next: got y=%h ch=%0d required y=44 ch=3", y, y_ch);
    else n_pass++;
    en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; en = 1'b1; out_ready = 1'b0;
    step();
    en = 1'b0; rst = 1'b1;
    step();
    n_checks++;
    if (y_valid !== 1'b0 || y !== 8'h00 || cur_sel !== 2'd0)
      $display("FAIL reset_mid: got v=%b y=%h sel=%0d required v=0 y=00 sel=0", y_valid, y, cur_sel);
    else n_pass++;
    rst = 1'b0; out_ready = 1'b1;
    step();
  endtask

`ifdef MUX_CH_MASK_EN
  task automatic test_mask();
    logic [7:0] exp_y [4] = '{8'h22, 8'h44, 8'h22, 8'h44};
    ch_mask = 4'b0101; mode = 1'b1; sel = 2'd1; sel_load = 1'b1;
    step();
    sel_load = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (y !== exp_y[i]) $display("FAIL mask_seq[%0d]: got %h required %h", i, y, exp_y[i]);
      else n_pass++;
    end
    ch_mask = 4'b1111;
    step();
    n_checks++; if (y_valid !== 1'b0) $display("FAIL mask_drain: got %b required 0", y_valid); else n_pass++;
    step();
    n_checks++; if (y_valid !== 1'b0) $display("FAIL mask_none: got %b required 0", y_valid); else n_pass++;
    en = 1'b0; ch_mask = 4'b0000;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; sel_load = 1'b0; en = 1'b0; out_ready = 1'b1;
    din = 32'h44332211;
`ifdef MUX_CH_MASK_EN
    ch_mask = 4'b0000;
`endif
    test_reset();
    test_manual();
    test_scan_wrap();
    test_backpressure();
    test_collision();
    test_reset_mid();
`ifdef MUX_CH_MASK_EN
    test_mask();
`endif
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_nx1_seq.md
Name: mux_nx1_seq

Overview:
- Parametrised N-to-1, W-bit multiplexer with one registered output stage and a valid/ready output handshake.
- Two select modes:
  - manual: the select value is loaded from a port.
  - scan: the block steps round-robin through the channels, one channel per accepted sample.
- Used as the channel-serialising front end for downstream single-lane consumers.
- Successor to the fixed 4x1 1-bit combinational mux.

Parameters:
- N, 4, number of input channels (N >= 2; need not be a power of 2).
- W, 1, data width per channel in bits.
- SEL_W, $clog2(N), select width. Derived localparam, not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- mode, input, 1, 0 = manual select, 1 = scan.
- sel, input, SEL_W, channel index to load in manual mode.
- sel_load, input, 1, pulse: load sel into cur_sel.
- din, input, N*W, packed channels; channel k occupies din[k*W +: W].
- en, input, 1, request to capture a sample from the current channel.
- out_ready, input, 1, downstream ready.
- y, output, W, registered selected data.
- y_valid, output, 1, y holds an unconsumed sample.
- cur_sel, output, SEL_W, channel that the next capture will sample.
- y_ch, output, SEL_W, channel index that y was sampled from.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - y = 0, y_valid = 0, cur_sel = 0, y_ch = 0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-transfer drops any pending sample.
- capture = en && (!y_valid || out_ready).
- transfer = y_valid && out_ready.
- On capture:
  - y <= din[cur_sel*W +: W], y_ch <= cur_sel, y_valid <= 1.
  - Latency: din to y is 1 cycle.
- transfer && !capture: y_valid <= 0. y and y_ch keep their values.
- !capture && !transfer: y, y_ch and y_valid are held. Data is stable while y_valid && !out_ready.
- Select register:
  - sel_load && sel < N: cur_sel <= sel, in either mode.
  - sel >= N: the load is ignored and cur_sel is unchanged. Only reachable when N is not a power of 2.
  - Scan mode, capture, no sel_load: cur_sel <= (cur_sel == N-1) ? 0 : cur_sel + 1. Wraps from N-1 to 0.
  - Manual mode: cur_sel changes only on sel_load.
  - Simultaneous valid sel_load and scan-mode capture: the capture samples the old cur_sel, then sel_load wins the update.
- Mode change takes effect next cycle. cur_sel is not reset by a mode change.
- Throughput: one sample per cycle while en = 1 and out_ready = 1.

Optional Feature:
- Macro: MUX_CH_MASK_EN.
- Defined:
  - Adds input port ch_mask, N bits; bit k = 1 masks channel k.
  - In scan mode the advance goes to the next unmasked channel after cur_sel, circularly.
  - In scan mode a capture is suppressed (capture forced to 0) if ch_mask[cur_sel] = 1.
  - All channels masked: no captures; y_valid drains normally.
  - Manual mode ignores ch_mask.
- Undefined:
  - No ch_mask port.
  - Behaviour is exactly as above with all channels unmasked.

Decomposition:
- Package mux_pkg:
  - mode constants MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1.
  - a next_idx wrap function (index, N -> next index).
- Sub-module mux_nx1_comb:
  - purely combinational N-way, W-bit select.
  - same N and W parameters.
  - instantiated once for the data path.
- Handshake, select register and scan logic stay in mux_nx1_seq.

Test Plan:
All tests use N = 4, W = 8, din = {8'h44, 8'h33, 8'h22, 8'h11} (ch0 = 11).
- Reset: assert rst with en = 1 for 2 cycles -> y = 00, y_valid = 0, cur_sel = 0; first capture after release gives y = 11, y_ch = 0.
- Manual mode:
  - sel = 2, sel_load pulse, then en = 1 with out_ready = 1 -> y = 33 one cycle later.
  - Holding en produces repeated 33; cur_sel stays 2.
- Scan wrap: mode = 1, en = 1, out_ready = 1 for 6 cycles -> y sequence 11, 22, 33, 44, 11, 22; y_ch 0, 1, 2, 3, 0, 1.
- Backpressure:
  - Scan mode, out_ready = 0 for 3 cycles after the first capture -> y = 11 held, y_valid = 1, cur_sel = 1 frozen.
  - On out_ready = 1, next y = 22, with no sample lost or duplicated.
- Collision: scan mode at cur_sel = 1, same cycle sel_load with sel = 3 and capture -> y = 22, then cur_sel = 3, next y = 44.
- Mask (MUX_CH_MASK_EN): ch_mask = 4'b0101, scan mode -> y sequence 22, 44, 22, 44. ch_mask = 4'b1111 -> y_valid drops after drain, no new captures.
